bsg_cache_dma_arbiter: RTL and testbench
========================================

BSG_CACHE_DMA_ARBITER -- requirements
Module: bsg_cache_dma_arbiter

Interface
REQ-001 SHALL have parameter num_cache_p, default 4, meaning number of caches sharing one DMA channel (>=2).
REQ-002 SHALL have parameter addr_width_p, default 32, meaning DMA packet address width.
REQ-003 SHALL have parameter data_width_p, default 64, meaning DMA data beat width.
REQ-004 SHALL have parameter block_size_in_words_p, default 8, meaning data beats per block (>=1).
REQ-005 SHALL have ports: clk_i in 1, the single clock; reset_i in 1, asynchronous active-high reset.
REQ-006 SHALL have cache-side ports: dma_pkt_i in num_cache_p*(addr_width_p+1), per cache {write_not_read, addr}; dma_pkt_v_i in num_cache_p; dma_pkt_yumi_o out num_cache_p.
REQ-007 SHALL have cache-side fill ports: dma_data_o out data_width_p, broadcast; dma_data_v_o out num_cache_p; dma_data_ready_i in num_cache_p.
REQ-008 SHALL have cache-side evict ports: dma_data_i in num_cache_p*data_width_p; dma_data_v_i in num_cache_p; dma_data_yumi_o out num_cache_p.
REQ-009 SHALL have memory-side ports: mem_pkt_o out addr_width_p+1; mem_pkt_v_o out 1; mem_pkt_yumi_i in 1; mem_cache_id_o out clog2(num_cache_p), the owner id.
REQ-010 SHALL have memory-side data ports: mem_fill_data_i in data_width_p; mem_fill_v_i in 1; mem_fill_ready_o out 1; mem_evict_data_o out data_width_p; mem_evict_v_o out 1; mem_evict_yumi_i in 1.

Function
REQ-011 SHALL implement states e_arb_idle, e_arb_fill, e_arb_evict; exactly one transaction owns the channel at a time.
REQ-012 In e_arb_idle, SHALL select one requester among dma_pkt_v_i by round-robin, starting search at rr pointer.
REQ-013 SHALL drive mem_pkt_o/mem_cache_id_o from the selected requester combinationally; mem_pkt_v_o = any dma_pkt_v_i in e_arb_idle, else 0.
REQ-014 SHALL assert dma_pkt_yumi_o[g] only in the cycle of mem_pkt_v_o & mem_pkt_yumi_i, g = selected cache.
REQ-015 On packet handshake, SHALL latch owner g, set rr pointer to (g+1) mod num_cache_p, load beat counter to block_size_in_words_p-1.
REQ-016 On handshake, SHALL go to e_arb_fill if write_not_read=0, else e_arb_evict.
REQ-017 Selection SHALL not change while mem_pkt_v_o is high and mem_pkt_yumi_i is low, unless the selected request drops.
REQ-018 In e_arb_fill, SHALL route mem_fill_data_i to dma_data_o, dma_data_v_o[owner]=mem_fill_v_i, mem_fill_ready_o=dma_data_ready_i[owner]; other bits 0.
REQ-019 In e_arb_evict, SHALL route dma_data_i[owner] to mem_evict_data_o, mem_evict_v_o=dma_data_v_i[owner], dma_data_yumi_o[owner]=mem_evict_yumi_i.
REQ-020 Each beat handshake SHALL decrement the counter; the handshake with counter=0 SHALL return to e_arb_idle next cycle.
REQ-021 No new packet SHALL be granted in the cycle the last beat completes (one idle cycle minimum between transactions).
REQ-022 Outside the owning state, mem_fill_ready_o, mem_evict_v_o, all dma_data_v_o and dma_data_yumi_o SHALL be 0.
REQ-023 With block_size_in_words_p=1, SHALL return to idle after exactly one beat.
REQ-024 A single continuously requesting cache SHALL be granted every transaction; with all requesting, grant order SHALL be 0,1,...,N-1,0.

Reset
REQ-025 On reset_i asserted (any time, incl. mid-transaction), state SHALL become e_arb_idle, rr pointer 0, counter 0, owner 0 immediately.
REQ-026 During reset, all v/yumi/ready outputs SHALL be 0; an interrupted transaction is abandoned without completion.

Structure
REQ-027 Enum bsg_cache_dma_arb_state_e (2 bits) SHALL be added to bsg_cache_pkg.
REQ-028 Round-robin selection SHALL be a sub-module bsg_cache_dma_rr_arb (request vector, pointer in; one-hot grant, id out).

Verification
REQ-029 Reset, cache 2 requests read addr 0x100, yumi_i=1 -> pkt yumi[2] same cycle, mem_cache_id_o=2, 8 fill beats to cache 2 only, idle.
REQ-030 All 4 caches request continuously, alternating read/write -> grants 0,1,2,3,0, each holding channel exactly 8 beats.
REQ-031 Evict from cache 1 with mem_evict_yumi_i toggling 1,0 -> 8 beats forwarded in order, no beat dropped or duplicated.
REQ-032 Fill with dma_data_ready_i[3]=0 for 5 cycles -> mem_fill_ready_o=0 for those cycles, counter holds.
REQ-033 reset_i asserted after beat 3 of a fill -> outputs 0 that cycle, next request from cache 0 granted normally.
REQ-034 mem_pkt_yumi_i=0 for 4 cycles with caches 1,2 requesting -> mem_cache_id_o stays 1 until handshake.

Source files
------------

// File: rtl/bsg_cache_pkg.sv
// Shared cache-side types: DMA arbiter state encoding and a width helper.
// No logic; imported by the DMA arbiter and its round-robin selector.
package bsg_cache_pkg;

    typedef enum logic [1:0] {
        e_arb_idle  = 2'd0,
        e_arb_fill  = 2'd1,
        e_arb_evict = 2'd2
    } bsg_cache_dma_arb_state_e;

    // clog2 that never returns 0, so single-entry counters still get one bit
    function automatic int bsg_safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_cache_dma_rr_arb.sv
// Round-robin pick over a request vector starting at ptr_i; purely combinational (0 cycles).
// No backpressure of its own: the caller decides when a grant is consumed.
module bsg_cache_dma_rr_arb
    import bsg_cache_pkg::*;
#(
    parameter int num_p    = 4,
    parameter int lg_num_p = bsg_safe_clog2(num_p)
) (
    input  logic [num_p-1:0]    reqs_i,
    input  logic [lg_num_p-1:0] ptr_i,
    output logic [num_p-1:0]    grant_o,
    output logic [lg_num_p-1:0] id_o,
    output logic                v_o
);

    logic [lg_num_p:0] idx;
    logic [num_p-1:0]  rot;

    always_comb begin
        grant_o = '0;
        id_o    = '0;
        v_o     = 1'b0;
        idx     = '0;
        rot     = '0;
        for (int k = 0; k < num_p; k++) begin
            // ptr_i < num_p, so one conditional subtract gives the modulo
            idx = {1'b0, ptr_i} + k[lg_num_p:0];
            if (idx >= (lg_num_p+1)'(num_p)) begin
                idx = idx - (lg_num_p+1)'(num_p);
            end
            rot = reqs_i >> idx;
            if (!v_o && rot[0]) begin
                v_o     = 1'b1;
                id_o    = idx[lg_num_p-1:0];
                grant_o = {{(num_p-1){1'b0}}, 1'b1} << idx;
            end
        end
    end

endmodule

// File: rtl/bsg_cache_dma_arbiter.sv
// Shares one DMA channel among caches, one block transaction at a time; packet grant is same-cycle.
// Backpressure passes straight through between owner and memory; at least one idle cycle per transaction.
module bsg_cache_dma_arbiter
    import bsg_cache_pkg::*;
#(
    parameter int num_cache_p           = 4,
    parameter int addr_width_p          = 32,
    parameter int data_width_p          = 64,
    parameter int block_size_in_words_p = 8,
    localparam int lg_num_cache_lp      = $clog2(num_cache_p),
    localparam int lg_block_lp          = bsg_safe_clog2(block_size_in_words_p),
    localparam int pkt_width_lp         = addr_width_p + 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,

    input  logic [num_cache_p*pkt_width_lp-1:0]   dma_pkt_i,
    input  logic [num_cache_p-1:0]                dma_pkt_v_i,
    output logic [num_cache_p-1:0]                dma_pkt_yumi_o,

    output logic [data_width_p-1:0]               dma_data_o,
    output logic [num_cache_p-1:0]                dma_data_v_o,
    input  logic [num_cache_p-1:0]                dma_data_ready_i,

    input  logic [num_cache_p*data_width_p-1:0]   dma_data_i,
    input  logic [num_cache_p-1:0]                dma_data_v_i,
    output logic [num_cache_p-1:0]                dma_data_yumi_o,

    output logic [pkt_width_lp-1:0]               mem_pkt_o,
    output logic                                  mem_pkt_v_o,
    input  logic                                  mem_pkt_yumi_i,
    output logic [lg_num_cache_lp-1:0]            mem_cache_id_o,

    input  logic [data_width_p-1:0]               mem_fill_data_i,
    input  logic                                  mem_fill_v_i,
    output logic                                  mem_fill_ready_o,
    output logic [data_width_p-1:0]               mem_evict_data_o,
    output logic                                  mem_evict_v_o,
    input  logic                                  mem_evict_yumi_i
);

    bsg_cache_dma_arb_state_e state_q, state_d;
    logic [lg_num_cache_lp-1:0] owner_q, owner_d;
    logic [lg_num_cache_lp-1:0] rr_q, rr_d;
    logic [lg_block_lp-1:0]     cnt_q, cnt_d;
    logic                       lock_q, lock_d;
    logic [lg_num_cache_lp-1:0] lock_id_q, lock_id_d;

    logic [num_cache_p-1:0]     rr_grant;
    logic [lg_num_cache_lp-1:0] rr_id;
    logic                       rr_v;

    bsg_cache_dma_rr_arb #(
        .num_p    (num_cache_p),
        .lg_num_p (lg_num_cache_lp)
    ) rr_arb (
        .reqs_i  (dma_pkt_v_i),
        .ptr_i   (rr_q),
        .grant_o (rr_grant),
        .id_o    (rr_id),
        .v_o     (rr_v)
    );

    // An offered but unaccepted packet stays selected while its requester holds valid
    logic                       use_lock;
    logic [lg_num_cache_lp-1:0] sel_id;
    logic [num_cache_p-1:0]     sel_oh;
    logic [pkt_width_lp-1:0]    sel_pkt;

    assign use_lock = lock_q & dma_pkt_v_i[lock_id_q];
    assign sel_id   = use_lock ? lock_id_q : rr_id;
    assign sel_oh   = use_lock ? ({{(num_cache_p-1){1'b0}}, 1'b1} << lock_id_q) : rr_grant;
    assign sel_pkt  = dma_pkt_i[sel_id*pkt_width_lp +: pkt_width_lp];

    logic pkt_v, pkt_hs, fill_hs, evict_hs;

    assign pkt_v    = (state_q == e_arb_idle) & rr_v & ~reset_i;
    assign pkt_hs   = pkt_v & mem_pkt_yumi_i;
    assign fill_hs  = (state_q == e_arb_fill) & ~reset_i & mem_fill_v_i & dma_data_ready_i[owner_q];
    assign evict_hs = (state_q == e_arb_evict) & ~reset_i & dma_data_v_i[owner_q] & mem_evict_yumi_i;

    assign mem_pkt_v_o      = pkt_v;
    assign mem_pkt_o        = sel_pkt;
    assign mem_cache_id_o   = sel_id;
    assign dma_data_o       = mem_fill_data_i;
    assign mem_evict_data_o = dma_data_i[owner_q*data_width_p +: data_width_p];

    always_comb begin
        dma_pkt_yumi_o   = '0;
        dma_data_v_o     = '0;
        dma_data_yumi_o  = '0;
        mem_fill_ready_o = 1'b0;
        mem_evict_v_o    = 1'b0;
        if (pkt_hs) begin
            dma_pkt_yumi_o = sel_oh;
        end
        if (!reset_i) begin
            case (state_q)
                e_arb_fill: begin
                    dma_data_v_o[owner_q] = mem_fill_v_i;
                    mem_fill_ready_o      = dma_data_ready_i[owner_q];
                end
                e_arb_evict: begin
                    mem_evict_v_o            = dma_data_v_i[owner_q];
                    dma_data_yumi_o[owner_q] = mem_evict_yumi_i;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        case (state_q)
            e_arb_idle: begin
                lock_d    = pkt_v & ~mem_pkt_yumi_i;
                lock_id_d = sel_id;
                if (pkt_hs) begin
                    owner_d = sel_id;
                    rr_d    = (sel_id == lg_num_cache_lp'(num_cache_p-1)) ? '0 : sel_id + 1'b1;
                    cnt_d   = lg_block_lp'(block_size_in_words_p-1);
                    state_d = sel_pkt[addr_width_p] ? e_arb_evict : e_arb_fill;
                end
            end
            e_arb_fill, e_arb_evict: begin
                if (fill_hs || evict_hs) begin
                    if (cnt_q == '0) begin
                        state_d = e_arb_idle;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = e_arb_idle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= e_arb_idle;
            owner_q   <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

endmodule

// File: tb/tb_bsg_cache_dma_arbiter.sv
// Randomized bench for the DMA arbiter: drivers push expected packets/beats into queues,
// a negedge monitor pops them and checks against a transaction-level channel model.
module tb_bsg_cache_dma_arbiter;

    localparam int N  = 4;
    localparam int A  = 32;
    localparam int D  = 64;
    localparam int B  = 8;
    localparam int PW = A + 1;
    localparam int LG = $clog2(N);

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b1;
    logic [N*PW-1:0]   dma_pkt_i = '0;
    logic [N-1:0]      dma_pkt_v_i = '0;
    logic [N-1:0]      dma_pkt_yumi_o;
    logic [D-1:0]      dma_data_o;
    logic [N-1:0]      dma_data_v_o;
    logic [N-1:0]      dma_data_ready_i = '0;
    logic [N*D-1:0]    dma_data_i = '0;
    logic [N-1:0]      dma_data_v_i = '0;
    logic [N-1:0]      dma_data_yumi_o;
    logic [PW-1:0]     mem_pkt_o;
    logic              mem_pkt_v_o;
    logic              mem_pkt_yumi_i = 1'b0;
    logic [LG-1:0]     mem_cache_id_o;
    logic [D-1:0]      mem_fill_data_i = '0;
    logic              mem_fill_v_i = 1'b0;
    logic              mem_fill_ready_o;
    logic [D-1:0]      mem_evict_data_o;
    logic              mem_evict_v_o;
    logic              mem_evict_yumi_i = 1'b0;

    bsg_cache_dma_arbiter #(
        .num_cache_p(N), .addr_width_p(A), .data_width_p(D), .block_size_in_words_p(B)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
        .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_ready_i(dma_data_ready_i),
        .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
        .mem_pkt_o(mem_pkt_o), .mem_pkt_v_o(mem_pkt_v_o), .mem_pkt_yumi_i(mem_pkt_yumi_i),
        .mem_cache_id_o(mem_cache_id_o),
        .mem_fill_data_i(mem_fill_data_i), .mem_fill_v_i(mem_fill_v_i), .mem_fill_ready_o(mem_fill_ready_o),
        .mem_evict_data_o(mem_evict_data_o), .mem_evict_v_o(mem_evict_v_o), .mem_evict_yumi_i(mem_evict_yumi_i)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    // scoreboard queues, filled by the drivers
    logic [PW-1:0] pkt_q [N][$];
    logic [D-1:0]  ev_q  [N][$];
    logic [D-1:0]  fill_q[$];

    // handshake notifications from monitor to drivers
    logic [N-1:0] took = '0;
    logic [N-1:0] ev_took = '0;
    logic         fill_took = 1'b0;

    // stimulus knobs
    logic [N-1:0] req_mask = '0;
    int wr_mode = 0;
    int p_req = 100, p_pyumi = 100, p_fv = 100, p_rdy = 100, p_evv = 100, p_eyumi = 100, p_rst = 0;
    logic ev_toggle = 1'b0;
    logic ev_tog = 1'b0;
    logic [A-1:0] addr_fix = '0;

    logic [N-1:0]  pend = '0;
    logic [N-1:0]  alt_wr = '0;
    logic [PW-1:0] pkt_val [N];
    logic [D-1:0]  ev_val [N];
    logic [D-1:0]  fill_val;

    // channel model
    logic active = 1'b0;
    logic is_wr = 1'b0;
    int   owner = 0;
    int   remaining = 0;
    int   ptr = 0;
    logic offering = 1'b0;
    int   offer_id = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    function automatic logic pct(input int p);
        return int'($urandom % 100) < p;
    endfunction

    always @(negedge clk_i) begin
        logic busy_now;
        logic exp_v;
        logic [PW-1:0] e_pkt;
        logic [D-1:0] e_dat;
        if (reset_i) begin
            chk("rst_pkt_v", mem_pkt_v_o, 0);
            chk("rst_pkt_yumi", dma_pkt_yumi_o, 0);
            chk("rst_data_v", dma_data_v_o, 0);
            chk("rst_data_yumi", dma_data_yumi_o, 0);
            chk("rst_fill_rdy", mem_fill_ready_o, 0);
            chk("rst_evict_v", mem_evict_v_o, 0);
            active = 1'b0; offering = 1'b0; ptr = 0; remaining = 0;
        end else begin
            busy_now = active;
            if (busy_now && !is_wr) begin
                chk("fill_data_v", dma_data_v_o, 128'(mem_fill_v_i) << owner);
                chk("fill_ready", mem_fill_ready_o, dma_data_ready_i[owner]);
                chk("fill_evict_v", mem_evict_v_o, 0);
                chk("fill_data_yumi", dma_data_yumi_o, 0);
                if (mem_fill_v_i && dma_data_ready_i[owner]) begin
                    e_dat = fill_q.pop_front();
                    chk("fill_beat", dma_data_o, e_dat);
                    fill_took = 1'b1;
                    remaining--;
                    if (remaining == 0) active = 1'b0;
                end
            end else if (busy_now && is_wr) begin
                chk("evict_v", mem_evict_v_o, dma_data_v_i[owner]);
                chk("evict_data_yumi", dma_data_yumi_o, 128'(mem_evict_yumi_i) << owner);
                chk("evict_data_v", dma_data_v_o, 0);
                chk("evict_fill_rdy", mem_fill_ready_o, 0);
                if (dma_data_v_i[owner] && mem_evict_yumi_i) begin
                    e_dat = ev_q[owner].pop_front();
                    chk("evict_beat", mem_evict_data_o, e_dat);
                    ev_took[owner] = 1'b1;
                    remaining--;
                    if (remaining == 0) active = 1'b0;
                end
            end else begin
                chk("idle_data_v", dma_data_v_o, 0);
                chk("idle_data_yumi", dma_data_yumi_o, 0);
                chk("idle_fill_rdy", mem_fill_ready_o, 0);
                chk("idle_evict_v", mem_evict_v_o, 0);
            end

            exp_v = !busy_now && (dma_pkt_v_i != '0);
            chk("pkt_v", mem_pkt_v_o, exp_v);
            if (exp_v) begin
                if (!offering) begin
                    offer_id = rr_pick(dma_pkt_v_i, ptr);
                    offering = 1'b1;
                end
                chk("pkt_id", mem_cache_id_o, offer_id);
                if (pkt_q[offer_id].size() == 0) begin
                    miscompares++;
                    $display("FAIL pkt_q: no pending packet for cache %0d", offer_id);
                end else begin
                    e_pkt = pkt_q[offer_id][0];
                    chk("pkt_dat", mem_pkt_o, e_pkt);
                    if (mem_pkt_yumi_i) begin
                        chk("pkt_yumi", dma_pkt_yumi_o, 128'(1) << offer_id);
                        void'(pkt_q[offer_id].pop_front());
                        took[offer_id] = 1'b1;
                        active = 1'b1;
                        owner = offer_id;
                        is_wr = e_pkt[A];
                        remaining = B;
                        ptr = (offer_id + 1) % N;
                        offering = 1'b0;
                    end else begin
                        chk("pkt_yumi_hold", dma_pkt_yumi_o, 0);
                    end
                end
            end else begin
                chk("pkt_yumi_none", dma_pkt_yumi_o, 0);
            end
        end
    end

    task automatic step();
        logic w;
        @(posedge clk_i);
        #1;
        reset_i = (p_rst != 0) && (int'($urandom_range(0, 999)) < p_rst);
        for (int i = 0; i < N; i++) begin
            if (took[i]) begin
                pend[i] = 1'b0;
                took[i] = 1'b0;
            end
            if (ev_took[i]) begin
                ev_took[i] = 1'b0;
                ev_val[i] = {$urandom, $urandom};
                ev_q[i].push_back(ev_val[i]);
            end
            if (!pend[i] && req_mask[i] && pct(p_req)) begin
                case (wr_mode)
                    0: w = 1'b0;
                    1: w = 1'b1;
                    3: begin w = alt_wr[i]; alt_wr[i] = ~alt_wr[i]; end
                    default: w = 1'($urandom);
                endcase
                pkt_val[i] = {w, (addr_fix != '0) ? addr_fix : A'($urandom)};
                pkt_q[i].push_back(pkt_val[i]);
                pend[i] = 1'b1;
            end
            dma_pkt_v_i[i] = pend[i];
            dma_pkt_i[i*PW +: PW] = pkt_val[i];
            dma_data_i[i*D +: D] = ev_val[i];
            dma_data_v_i[i] = pct(p_evv);
            dma_data_ready_i[i] = pct(p_rdy);
        end
        if (fill_took) begin
            fill_took = 1'b0;
            fill_val = {$urandom, $urandom};
            fill_q.push_back(fill_val);
        end
        mem_fill_data_i = fill_val;
        mem_fill_v_i = pct(p_fv);
        mem_pkt_yumi_i = pct(p_pyumi);
        if (ev_toggle) begin
            ev_tog = ~ev_tog;
            mem_evict_yumi_i = ev_tog;
        end else begin
            mem_evict_yumi_i = pct(p_eyumi);
        end
    endtask

    task automatic phase(input logic [N-1:0] mask, input int wm, input int cycles);
        req_mask = mask;
        wr_mode = wm;
        repeat (cycles) step();
        // drain: stop new requests and let outstanding work finish
        req_mask = '0;
        p_rst = 0;
        repeat (60) step();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pkt_val[i] = '0;
            ev_val[i] = {$urandom, $urandom};
            ev_q[i].push_back(ev_val[i]);
        end
        fill_val = {$urandom, $urandom};
        fill_q.push_back(fill_val);
        mem_fill_data_i = fill_val;
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;

        // single read from cache 2 at 0x100, memory always ready
        addr_fix = A'(32'h100);
        phase(4'b0100, 0, 3);
        addr_fix = '0;

        // every cache requesting continuously, alternating direction
        phase(4'b1111, 3, 200);

        // evicts from cache 1 with memory accepting every other cycle
        ev_toggle = 1'b1;
        phase(4'b0010, 1, 80);
        ev_toggle = 1'b0;

        // fills to cache 3 with a stalling consumer
        p_rdy = 30;
        phase(4'b1000, 0, 80);
        p_rdy = 100;

        // caches 1 and 2 competing while memory is slow to accept packets
        p_pyumi = 20;
        phase(4'b0110, 2, 120);

        // fully random traffic with occasional mid-transaction resets
        p_pyumi = 50; p_fv = 60; p_rdy = 60; p_evv = 60; p_eyumi = 60; p_req = 40;
        p_rst = 4;
        phase(4'b1111, 2, 2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
